// File: rtl/rot_pkg.sv
// rot_pkg: shared byte/amount types and a reference rotate for the rotator arbiter
package rot_pkg;
    localparam int ROT_W = 8;
    typedef logic [2:0] rot_amt_t;
    typedef logic [ROT_W-1:0] rot_byte_t;
    function automatic rot_byte_t rotr_ref(input rot_byte_t d, input rot_amt_t a);
        logic [2*ROT_W-1:0] w_dd;
        w_dd = {d, d} >> a;
        return w_dd[ROT_W-1:0];
    endfunction
endpackage

// File: rtl/rot_share_arbiter_if.sv
// rot_share_arbiter_if: requester-side and result-side handshake bundle
interface rot_share_arbiter_if
    import rot_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    rot_byte_t [NUM_REQ-1:0] req_data;
    rot_amt_t [NUM_REQ-1:0] req_amt;
    logic out_valid;
    logic out_ready;
    rot_byte_t out_data;
    logic [ID_W-1:0] out_id;
    logic busy;
    modport master (
        output req_valid, req_data, req_amt, out_ready,
        input  req_ready, out_valid, out_data, out_id, busy
    );
    modport slave (
        input  req_valid, req_data, req_amt, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/barrel_shifter.sv
// barrel_shifter: 8-bit rotate-right by 0..7 in three log stages
module barrel_shifter
    import rot_pkg::*;
(
    input  rot_byte_t i_data,
    input  rot_amt_t  i_amt,
    output rot_byte_t o_data
);
    rot_byte_t w_s1, w_s2;
    assign w_s1   = i_amt[0] ? {i_data[0], i_data[7:1]} : i_data;
    assign w_s2   = i_amt[1] ? {w_s1[1:0], w_s1[7:2]} : w_s1;
    assign o_data = i_amt[2] ? {w_s2[3:0], w_s2[7:4]} : w_s2;
endmodule

// File: rtl/rot_share_arbiter.sv
// rot_share_arbiter: round-robin time-sharing of one byte rotator with a registered result port
module rot_share_arbiter
    import rot_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    rot_share_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [ID_W-1:0] r_rr_ptr, r_out_id, w_win;
    logic r_out_valid, w_any, w_load;
    rot_byte_t r_out_data, w_rot;
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any && bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_win = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
                w_any = 1'b1;
            end
        end
    end
    // a full register may be refilled in the same cycle it is drained
    assign w_load        = rst_n & en & (~r_out_valid | bus.out_ready) & w_any;
    assign bus.req_ready = w_load ? (NUM_REQ'(1) << w_win) : '0;
    barrel_shifter u_rot (
        .i_data (bus.req_data[w_win]),
        .i_amt  (bus.req_amt[w_win]),
        .o_data (w_rot)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rot;
            r_out_id    <= w_win;
            r_rr_ptr    <= ID_W'((int'(w_win) + 1) % NUM_REQ);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_id    = r_out_id;
    assign bus.busy      = r_out_valid | (|bus.req_valid);
endmodule
